// File: rtl/iq_pkg.sv
// Shared types and helpers for the multi-issue instruction queue.
package iq_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned MAX_LANES = 4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } iq_entry_t;

  // Counts set bits in a lane mask of up to MAX_LANES lanes.
  function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] mask);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {2'b00, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Pointer registers, occupancy, enqueue-ready / dequeue-valid generation and flush.
module iq_ptr_ctrl
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ENQ_W = 2,
  parameter int unsigned DEQ_W = 2,
  localparam int unsigned PW   = $clog2(DEPTH) + 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned TW   = $clog2(DEQ_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [ENQ_W-1:0] enq_valid,
  input  logic [TW-1:0]    deq_take,
  output logic [PW-1:0]    wr_ptr,
  output logic [PW-1:0]    rd_ptr,
  output logic [CW-1:0]    count,
  output logic             enq_ready,
  output logic             enq_fire,
  output logic [DEQ_W-1:0] deq_valid
);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, occ, n_deq;
  logic [2:0]    n_enq;

  always_comb begin
    occ       = wr_q - rd_q;
    // Ready looks only at registered occupancy, never at this cycle's dequeue.
    enq_ready = (int'(occ) + int'(ENQ_W)) <= int'(DEPTH);
    enq_fire  = enq_ready && !flush;
    n_enq     = enq_fire ? popcount(MAX_LANES'(enq_valid)) : 3'd0;
    if (int'(deq_take) > int'(occ)) begin
      n_deq = occ;
    end else begin
      n_deq = PW'(deq_take);
    end
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      wr_d = wr_q + PW'(n_enq);
      rd_d = rd_q + n_deq;
    end
    for (int i = 0; i < int'(DEQ_W); i++) begin
      deq_valid[i] = int'(occ) > i;
    end
    count  = CW'(occ);
    wr_ptr = wr_q;
    rd_ptr = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/multi_issue_inst_queue.sv
// Circular multi-lane instruction queue between fetch and dispatch.
// Optional IQ_PERF_EN adds saturating stall/empty cycle counters.
module multi_issue_inst_queue
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ENQ_W = 2,
  parameter int unsigned DEQ_W = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned TW   = $clog2(DEQ_W + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic [ENQ_W-1:0]             enq_valid_in,
  input  logic [ENQ_W-1:0][INST_W-1:0] enq_inst_in,
  input  logic [ENQ_W-1:0][PC_W-1:0]   enq_pc_in,
  output logic                         enq_ready_out,
  output logic [DEQ_W-1:0]             deq_valid_out,
  output logic [DEQ_W-1:0][INST_W-1:0] deq_inst_out,
  output logic [DEQ_W-1:0][PC_W-1:0]   deq_pc_out,
  input  logic [TW-1:0]                deq_take_in,
  output logic [CW-1:0]                count_out
`ifdef IQ_PERF_EN
  ,
  output logic [31:0]                  stall_cycles_out,
  output logic [31:0]                  empty_cycles_out
`endif
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          enq_fire;
  logic [IW-1:0] rd_idx [DEQ_W];
  iq_entry_t     mem    [DEPTH];

  iq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .ENQ_W (ENQ_W),
    .DEQ_W (DEQ_W)
  ) u_ptr_ctrl (
    .clk       (clk_in),
    .rst       (rst_in),
    .flush     (flush_in),
    .enq_valid (enq_valid_in),
    .deq_take  (deq_take_in),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count_out),
    .enq_ready (enq_ready_out),
    .enq_fire  (enq_fire),
    .deq_valid (deq_valid_out)
  );

  // Storage is deliberately not reset; valid lanes gate what is visible.
  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      for (int i = 0; i < int'(ENQ_W); i++) begin
        if (enq_valid_in[i]) begin
          mem[wr_ptr[IW-1:0] + IW'(i)] <= '{inst: enq_inst_in[i], pc: enq_pc_in[i]};
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEQ_W); i++) begin
      rd_idx[i]       = rd_ptr[IW-1:0] + IW'(i);
      deq_inst_out[i] = '0;
      deq_pc_out[i]   = '0;
      if (deq_valid_out[i]) begin
        deq_inst_out[i] = mem[rd_idx[i]].inst;
        deq_pc_out[i]   = mem[rd_idx[i]].pc;
      end
    end
  end

`ifdef IQ_PERF_EN
  logic [31:0] stall_q, empty_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q <= '0;
      empty_q <= '0;
    end else begin
      if (enq_valid_in[0] && !enq_ready_out && stall_q != 32'hFFFF_FFFF) begin
        stall_q <= stall_q + 32'd1;
      end
      if (count_out == '0 && empty_q != 32'hFFFF_FFFF) begin
        empty_q <= empty_q + 32'd1;
      end
    end
  end

  assign stall_cycles_out = stall_q;
  assign empty_cycles_out = empty_q;
`endif

endmodule

// File: tb/tb_multi_issue_inst_queue.sv
// Directed self-checking bench for multi_issue_inst_queue (DEPTH 8, 2 enq / 2 deq lanes).
module tb_multi_issue_inst_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ENQ_W = 2;
  localparam int unsigned DEQ_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       enq_valid = 2'b00;
  logic [1:0][31:0] enq_inst = '0;
  logic [1:0][31:0] enq_pc = '0;
  logic             enq_ready;
  logic [1:0]       deq_valid;
  logic [1:0][31:0] deq_inst;
  logic [1:0][31:0] deq_pc;
  logic [1:0]       deq_take = 2'd0;
  logic [3:0]       count;
`ifdef IQ_PERF_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      empty_cycles;
`endif

  int checks = 0;
  int errors = 0;

  multi_issue_inst_queue #(
    .DEPTH (DEPTH),
    .ENQ_W (ENQ_W),
    .DEQ_W (DEQ_W)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .flush_in         (flush),
    .enq_valid_in     (enq_valid),
    .enq_inst_in      (enq_inst),
    .enq_pc_in        (enq_pc),
    .enq_ready_out    (enq_ready),
    .deq_valid_out    (deq_valid),
    .deq_inst_out     (deq_inst),
    .deq_pc_out       (deq_pc),
    .deq_take_in      (deq_take),
    .count_out        (count)
`ifdef IQ_PERF_EN
    ,
    .stall_cycles_out (stall_cycles),
    .empty_cycles_out (empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert ((enq_valid & (enq_valid + 2'd1)) == 2'b00)
      else $error("enq_valid not contiguous: %b", enq_valid);
  end

  function automatic logic [31:0] fi(input int k);
    return 32'h13 + 32'h80 * k;
  endfunction
  function automatic logic [31:0] fp(input int k);
    return 32'd4 * k;
  endfunction
  function automatic logic [31:0] wi(input int k);
    return 32'h1000_0000 + k;
  endfunction
  function automatic logic [31:0] wp(input int k);
    return 32'h8000 + 32'd4 * k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int h = 0;
  int t = 0;

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", enq_ready); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", deq_valid); end
    checks++; if (deq_inst !== '0) begin errors++; $display("FAIL reset_inst got %h exp 0", deq_inst); end
    checks++; if (deq_pc !== '0) begin errors++; $display("FAIL reset_pc got %h exp 0", deq_pc); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) begin
      enq_valid = 2'b11;
      enq_inst[0] = fi(2 * c); enq_inst[1] = fi(2 * c + 1);
      enq_pc[0] = fp(2 * c);   enq_pc[1] = fp(2 * c + 1);
      step();
      checks++; if (count !== 4'(2 * c + 2)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, 2 * c + 2); end
      if (c == 0) begin
        checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL fill_first_valid got %b exp 11", deq_valid); end
        checks++; if (deq_inst[0] !== fi(0)) begin errors++; $display("FAIL fill_first_inst got %h exp %h", deq_inst[0], fi(0)); end
        checks++; if (deq_pc[1] !== fp(1)) begin errors++; $display("FAIL fill_first_pc got %h exp %h", deq_pc[1], fp(1)); end
      end
    end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", enq_ready); end
    enq_inst[0] = 32'hDEAD_BEEF; enq_inst[1] = 32'hDEAD_BEEF;
    enq_pc[0] = 32'hFFFF_0000;   enq_pc[1] = 32'hFFFF_0004;
    step();
    enq_valid = 2'b00;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_reject_count got %0d exp 8", count); end
    checks++; if (deq_inst[0] !== fi(0)) begin errors++; $display("FAIL full_reject_head got %h exp %h", deq_inst[0], fi(0)); end
  endtask

  task automatic test_drain();
    for (int j = 0; j < 4; j++) begin
      checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL drain_valid got %b exp 11", deq_valid); end
      checks++; if (deq_inst[0] !== fi(2 * j)) begin errors++; $display("FAIL drain_inst0 got %h exp %h", deq_inst[0], fi(2 * j)); end
      checks++; if (deq_pc[0] !== fp(2 * j)) begin errors++; $display("FAIL drain_pc0 got %h exp %h", deq_pc[0], fp(2 * j)); end
      checks++; if (deq_inst[1] !== fi(2 * j + 1)) begin errors++; $display("FAIL drain_inst1 got %h exp %h", deq_inst[1], fi(2 * j + 1)); end
      checks++; if (deq_pc[1] !== fp(2 * j + 1)) begin errors++; $display("FAIL drain_pc1 got %h exp %h", deq_pc[1], fp(2 * j + 1)); end
      deq_take = 2'd2;
      step();
      deq_take = 2'd0;
      checks++; if (count !== 4'(6 - 2 * j)) begin errors++; $display("FAIL drain_count got %0d exp %0d", count, 6 - 2 * j); end
    end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL empty_valid got %b exp 00", deq_valid); end
    checks++; if (deq_inst !== '0) begin errors++; $display("FAIL empty_inst got %h exp 0", deq_inst); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %b exp 1", enq_ready); end
  endtask

  task automatic test_wrap();
    h = 0; t = 0;
    for (int c = 0; c < 3; c++) begin
      enq_valid = 2'b11;
      enq_inst[0] = wi(t); enq_inst[1] = wi(t + 1);
      enq_pc[0] = wp(t);   enq_pc[1] = wp(t + 1);
      t += 2;
      step();
    end
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL wrap_fill_count got %0d exp 6", count); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (deq_inst[0] !== wi(h)) begin errors++; $display("FAIL wrap_inst0 got %h exp %h", deq_inst[0], wi(h)); end
      checks++; if (deq_pc[0] !== wp(h)) begin errors++; $display("FAIL wrap_pc0 got %h exp %h", deq_pc[0], wp(h)); end
      checks++; if (deq_inst[1] !== wi(h + 1)) begin errors++; $display("FAIL wrap_inst1 got %h exp %h", deq_inst[1], wi(h + 1)); end
      checks++; if (deq_pc[1] !== wp(h + 1)) begin errors++; $display("FAIL wrap_pc1 got %h exp %h", deq_pc[1], wp(h + 1)); end
      enq_valid = 2'b11;
      enq_inst[0] = wi(t); enq_inst[1] = wi(t + 1);
      enq_pc[0] = wp(t);   enq_pc[1] = wp(t + 1);
      deq_take = 2'd2;
      step();
      h += 2; t += 2;
      checks++; if (count !== 4'd6) begin errors++; $display("FAIL wrap_count got %0d exp 6", count); end
    end
    enq_valid = 2'b00;
    deq_take = 2'd0;
  endtask

  task automatic test_overtake();
    deq_take = 2'd2;
    step();
    step();
    h += 4;
    deq_take = 2'd1;
    step();
    h += 1;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL one_count got %0d exp 1", count); end
    checks++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL one_valid got %b exp 01", deq_valid); end
    checks++; if (deq_inst[0] !== wi(h)) begin errors++; $display("FAIL one_inst got %h exp %h", deq_inst[0], wi(h)); end
    checks++; if (deq_inst[1] !== 32'd0) begin errors++; $display("FAIL one_lane1 got %h exp 0", deq_inst[1]); end
    deq_take = 2'd2;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL clamp_count got %0d exp 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL clamp_valid got %b exp 00", deq_valid); end
    step();
    deq_take = 2'd0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL underflow_count got %0d exp 0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL underflow_ready got %b exp 1", enq_ready); end
  endtask

  task automatic test_flush();
    enq_valid = 2'b11;
    enq_inst[0] = 32'h11; enq_inst[1] = 32'h22;
    step();
    step();
    enq_valid = 2'b01;
    step();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_flush_count got %0d exp 5", count); end
    flush = 1'b1;
    enq_valid = 2'b11;
    enq_inst[0] = 32'h33; enq_inst[1] = 32'h44;
    deq_take = 2'd2;
    step();
    flush = 1'b0;
    enq_valid = 2'b00;
    deq_take = 2'd0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b exp 00", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", enq_ready); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_discard got %0d exp 0", count); end
    enq_valid = 2'b01;
    enq_inst[0] = 32'hABCD; enq_pc[0] = 32'h100;
    step();
    enq_valid = 2'b00;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL post_flush_count got %0d exp 1", count); end
    checks++; if (deq_inst[0] !== 32'hABCD) begin errors++; $display("FAIL post_flush_inst got %h exp abcd", deq_inst[0]); end
    checks++; if (deq_pc[0] !== 32'h100) begin errors++; $display("FAIL post_flush_pc got %h exp 100", deq_pc[0]); end
    deq_take = 2'd1;
    step();
    deq_take = 2'd0;
  endtask

`ifdef IQ_PERF_EN
  task automatic test_perf();
    logic [31:0] e0;
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL perf_stall got %0d exp 1", stall_cycles); end
    e0 = empty_cycles;
    step();
    step();
    step();
    checks++; if (empty_cycles !== e0 + 32'd3) begin errors++; $display("FAIL perf_empty got %0d exp %0d", empty_cycles, e0 + 32'd3); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_overtake();
    test_flush();
`ifdef IQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_issue_inst_queue.md
# multi_issue_inst_queue

Parametrised circular instruction queue between fetch and decode/dispatch of the superscalar core. Accepts up to ENQ_W instructions (with PC) per cycle and presents up to DEQ_W oldest entries in parallel, so the dispatcher can consume several per cycle. Supports a single-cycle flush for branch-mispredict recovery and exposes occupancy.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ max(ENQ_W, DEQ_W)
- ENQ_W, 2, enqueue lanes per cycle (1..4)
- DEQ_W, 2, dequeue lanes per cycle (1..4)
- clk_in  input  1  single clock, all state on rising edge
- rst_in  input  1  asynchronous, active-high reset
- flush_in  input  1  discard all entries this cycle
- enq_valid_in  input  ENQ_W  per-lane valid; must be contiguous from lane 0 (lane i set implies lane i-1 set)
- enq_inst_in  input  ENQ_W×32  instruction per lane
- enq_pc_in  input  ENQ_W×32  PC per lane
- enq_ready_out  output  1  high when free slots ≥ ENQ_W
- deq_valid_out  output  DEQ_W  lane i high when count > i
- deq_inst_out  output  DEQ_W×32  lane i = (i)-th oldest instruction; zero when lane invalid
- deq_pc_out  output  DEQ_W×32  matching PCs; zero when lane invalid
- deq_take_in  input  $clog2(DEQ_W+1)  entries consumed this cycle, oldest first
- count_out  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH entries {inst, pc}; not reset. Read/write pointers $clog2(DEPTH)+1 bits (wrap bit); count = wr_ptr − rd_ptr modulo 2^(ptr width).
- Enqueue: when enq_ready_out && !flush_in, lanes with enq_valid_in set write to slots wr_ptr+i (index modulo DEPTH); wr_ptr advances by popcount(enq_valid_in). All-or-nothing: enq_ready_out never depends on enq_valid_in.
- Dequeue: rd_ptr advances by min(deq_take_in, count) when !flush_in; oversize take clamps, never underflows.
- Flush: highest priority; rd_ptr ← wr_ptr-independent reset of both pointers to 0; same-cycle enqueue and dequeue ignored.
- Simultaneous enq+deq: both apply; count_next = count + n_enq − n_deq. Ready is computed from registered count only, so enqueue into a full queue is never accepted even if dequeue frees slots that cycle.
- Non-contiguous enq_valid_in is illegal; behaviour undefined (assertion in bench).

## Timing
- Reset (async assert, sync-released by system): pointers 0, count_out 0, enq_ready_out 1, deq_valid_out 0, deq_inst_out/deq_pc_out 0, perf counters 0.
- Write-to-visible latency: 1 cycle (entry enqueued at edge N appears on deq lanes after edge N).
- Dequeue outputs purely combinational from registered pointers and storage; no input-to-output combinational path except none (deq_take_in affects next state only).
- Flush asserted at edge N: count_out 0 and deq_valid_out 0 after edge N; enq_ready_out 1.
- Wrap-around: indices wrap modulo DEPTH with no bubble; full when count = DEPTH, empty when count = 0.

## Configuration
- IQ_PERF_EN defined: adds outputs stall_cycles_out [31:0] (cycles with enq_valid_in[0] && !enq_ready_out) and empty_cycles_out [31:0] (cycles with count = 0 and !rst); both saturate at 2^32−1, cleared only by reset, unaffected by flush.
- IQ_PERF_EN undefined: those ports and counters are absent; all other behaviour identical.

## Structure
- Package iq_pkg: INST_W = 32, PC_W = 32, typedef iq_entry_t {inst, pc}, helper function popcount for lane masks.
- One sub-module natural: iq_ptr_ctrl (pointer registers, count, ready/valid generation, flush), leaving storage and lane muxing in the top.

## Test plan
- Reset then idle -> count_out 0, enq_ready_out 1, deq_valid_out 2'b00, data lanes 0.
- Enqueue 2 per cycle (0x13/PC 0x0, 0x93/PC 0x4, …) four cycles, DEPTH 8 -> count 8, enq_ready_out 0; fifth enqueue ignored, no overwrite.
- Full queue, deq_take_in 2 each cycle -> lanes present entries in program order with matching PCs; count 6,4,2,0; deq_valid_out 0 at empty.
- Fill 6, take 2 + enqueue 2 per cycle for 10 cycles -> pointers wrap, order preserved, count stays 6.
- Count 1 with deq_take_in 2 -> only 1 consumed, count 0, no underflow.
- Count 5 with flush_in and enq_valid_in 2'b11 same cycle -> count 0 next cycle, enqueued data discarded; under IQ_PERF_EN, stall_cycles_out increments only on full-with-valid cycles.
